// File: rtl/diag_bus_arbiter.sv
// -----------------------------------------------------------------------------
// diag_bus_arbiter
//
// Owns the single memory-map RAM port. The CPU bus drives the port in normal
// operation. When diagnostics raises halt_req, the CPU is stalled through
// cpu_rdy, in-flight bus cycles are allowed to drain for SETTLE_EDGES
// synchronised phi2 falling edges, and then the port is handed over to the
// diagnostics address/data/we/cs. Read data is returned to the current owner.
// Any diagnostics select/write attempted without ownership is blocked and
// latches the sticky access_violation flag.
//
// Optional feature (compile-time macro ROM_WRITE_PROTECT_EN):
//   defined   : CPU writes whose captured address is >= ROM_BASE are dropped;
//               diagnostics writes while granted are always permitted.
//   undefined : every CPU write reaches RAM; ROM_BASE has no effect.
//
// Ports:
//   fpga_clk         in   system clock, rising edge
//   fpga_reset       in   synchronous active-high reset
//   cpu_phi2         in   CPU phase-2 clock (asynchronous to fpga_clk)
//   cpu_rw           in   CPU read/write, 1 = read
//   cpu_addr[15:0]   in   CPU address
//   cpu_wdata[7:0]   in   CPU write data
//   cpu_rdy          out  CPU ready, 0 stalls the CPU
//   cpu_rdata[7:0]   out  RAM read data to the CPU
//   cpu_data_oe      out  CPU data-bus drive enable
//   halt_req         in   diagnostics halt request level
//   granted          out  diagnostics owns the RAM port
//   diag_address     in   diagnostics address
//   diag_data_out    in   diagnostics write data
//   diag_we          in   diagnostics write enable
//   diag_cs          in   diagnostics chip select
//   diag_rdata[7:0]  out  RAM read data to diagnostics (8'h00 when not owner)
//   mem_addr[15:0]   out  RAM address
//   mem_wdata[7:0]   out  RAM write data
//   mem_we           out  RAM write strobe
//   mem_cs           out  RAM select
//   mem_rdata[7:0]   in   RAM read data
//   access_violation out  sticky ownership-violation flag
// -----------------------------------------------------------------------------
module diag_bus_arbiter #(
  parameter int          SYNC_STAGES  = 2,
  parameter int          SETTLE_EDGES = 2,
  parameter logic [15:0] ROM_BASE     = 16'hC000
) (
  input  logic        fpga_clk,
  input  logic        fpga_reset,
  input  logic        cpu_phi2,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_data_oe,
  input  logic        halt_req,
  output logic        granted,
  input  logic [15:0] diag_address,
  input  logic [7:0]  diag_data_out,
  input  logic        diag_we,
  input  logic        diag_cs,
  output logic [7:0]  diag_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_cs,
  input  logic [7:0]  mem_rdata,
  output logic        access_violation
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DIAG   = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

`ifdef ROM_WRITE_PROTECT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_EDGES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   phi2_s;
  logic                   phi2_d_r;
  logic                   phi2_fall_s;

  logic [15:0] cap_addr_r;
  logic [7:0]  cap_wdata_r;
  logic        cap_rw_r;

  logic        we_pend_r;
  logic        rom_block_s;
  logic        cpu_side_s;

  state_t      state_r;
  state_t      state_n;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_n;
  logic        cpu_rdy_r;
  logic        cpu_rdy_n;
  logic        granted_r;
  logic        granted_n;
  logic        violation_r;

  assign phi2_s      = sync_r[SYNC_STAGES-1];
  assign phi2_fall_s = phi2_d_r & ~phi2_s;

  // The CPU still owns the bus (and its write strobes) in RUN and DRAIN.
  assign cpu_side_s  = (state_r == ST_RUN) || (state_r == ST_DRAIN);

  // Only meaningful when write protection is compiled in; WP_EN folds it away otherwise.
  assign rom_block_s = WP_EN & (cap_addr_r >= ROM_BASE);

  // phi2 synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      phi2_d_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], cpu_phi2};
      phi2_d_r <= phi2_s;
    end
  end

  // Capture the CPU address/data/rw continuously while phi2 is high; the
  // values present on the last high clock are what the write uses.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      cap_addr_r  <= 16'h0000;
      cap_wdata_r <= 8'h00;
      cap_rw_r    <= 1'b1;
    end else if (phi2_s) begin
      cap_addr_r  <= cpu_addr;
      cap_wdata_r <= cpu_wdata;
      cap_rw_r    <= cpu_rw;
    end else begin
      cap_addr_r  <= cap_addr_r;
      cap_wdata_r <= cap_wdata_r;
      cap_rw_r    <= cap_rw_r;
    end
  end

  // One-clock CPU write strobe on the clock after a phi2 fall. A fall on the
  // same edge that enters DRAIN still produces its strobe, in DRAIN.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      we_pend_r <= 1'b0;
    end else begin
      we_pend_r <= phi2_fall_s & ~cap_rw_r & ~rom_block_s & cpu_side_s;
    end
  end

  // Arbitration state register and registered handshake outputs.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      state_r   <= ST_RUN;
      cnt_r     <= 4'd0;
      cpu_rdy_r <= 1'b1;
      granted_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      cpu_rdy_r <= cpu_rdy_n;
      granted_r <= granted_n;
    end
  end

  // Next-state logic. The grant is taken one clock after the final counted
  // fall so that the strobe from that fall is still issued on the CPU side.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    cpu_rdy_n = cpu_rdy_r;
    granted_n = granted_r;
    case (state_r)
      ST_RUN: begin
        // Counter held at zero so a fall coinciding with halt is not counted.
        cnt_n     = 4'd0;
        granted_n = 1'b0;
        if (halt_req) begin
          state_n   = ST_DRAIN;
          cpu_rdy_n = 1'b0;
        end else begin
          cpu_rdy_n = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          state_n   = ST_RUN;
          cpu_rdy_n = 1'b1;
          granted_n = 1'b0;
          cnt_n     = 4'd0;
        end else if (cnt_r == SETTLE_CNT) begin
          state_n   = ST_DIAG;
          granted_n = 1'b1;
        end else if (phi2_fall_s) begin
          cnt_n = cnt_r + 4'd1;
        end else begin
          cnt_n = cnt_r;
        end
      end
      ST_DIAG: begin
        if (!halt_req) begin
          state_n   = ST_RESUME;
          granted_n = 1'b0;
        end else begin
          granted_n = 1'b1;
        end
      end
      ST_RESUME: begin
        state_n   = ST_RUN;
        cpu_rdy_n = 1'b1;
        granted_n = 1'b0;
      end
      default: begin
        state_n   = ST_RUN;
        cnt_n     = 4'd0;
        cpu_rdy_n = 1'b1;
        granted_n = 1'b0;
      end
    endcase
  end

  // Sticky flag for diagnostics select/write attempted without ownership.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      violation_r <= 1'b0;
    end else if ((diag_cs | diag_we) & ~granted_r) begin
      violation_r <= 1'b1;
    end else begin
      violation_r <= violation_r;
    end
  end

  // RAM port mux. The diagnostics path is combinational so the controller
  // sees no added latency; unowned diagnostics requests never reach RAM.
  always_comb begin
    mem_addr    = cap_addr_r;
    mem_wdata   = cap_wdata_r;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    cpu_rdata   = mem_rdata;
    cpu_data_oe = 1'b0;
    diag_rdata  = 8'h00;
    case (state_r)
      ST_RUN, ST_DRAIN: begin
        mem_cs      = phi2_s;
        mem_we      = we_pend_r;
        cpu_data_oe = phi2_s & cpu_rw;
      end
      ST_DIAG: begin
        mem_addr   = diag_address;
        mem_wdata  = diag_data_out;
        mem_cs     = diag_cs;
        mem_we     = diag_we & diag_cs;
        diag_rdata = mem_rdata;
        cpu_rdata  = 8'h00;
      end
      ST_RESUME: begin
        // One quiet clock on the RAM port before the CPU takes it back.
        mem_cs = 1'b0;
        mem_we = 1'b0;
      end
      default: begin
        mem_cs = 1'b0;
        mem_we = 1'b0;
      end
    endcase
  end

  assign cpu_rdy          = cpu_rdy_r;
  assign granted          = granted_r;
  assign access_violation = violation_r;

endmodule

// File: tb/tb_diag_bus_arbiter.sv
// Self-checking bench for diag_bus_arbiter. A RAM model answers the DUT's
// port; expected contents live in a separate associative model written only
// by the bench from the intended transactions.
module tb_diag_bus_arbiter;

  logic        fpga_clk;
  logic        fpga_reset;
  logic        cpu_phi2;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic [7:0]  cpu_rdata;
  logic        cpu_data_oe;
  logic        halt_req;
  logic        granted;
  logic [15:0] diag_address;
  logic [7:0]  diag_data_out;
  logic        diag_we;
  logic        diag_cs;
  logic [7:0]  diag_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_cs;
  logic [7:0]  mem_rdata;
  logic        access_violation;

  int errors = 0;
  int checks = 0;

`ifdef ROM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam logic [15:0] ROM_BASE_TB = 16'hC000;

  diag_bus_arbiter #(.SYNC_STAGES(2), .SETTLE_EDGES(2), .ROM_BASE(16'hC000)) dut (
    .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .cpu_phi2(cpu_phi2),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata), .cpu_data_oe(cpu_data_oe),
    .halt_req(halt_req), .granted(granted), .diag_address(diag_address),
    .diag_data_out(diag_data_out), .diag_we(diag_we), .diag_cs(diag_cs),
    .diag_rdata(diag_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_cs(mem_cs), .mem_rdata(mem_rdata),
    .access_violation(access_violation)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // RAM model (synchronous write, combinational read) and strobe monitor.
  logic [7:0]  ram [0:65535];
  int          we_count = 0;
  int          granted_count = 0;
  logic [15:0] last_we_addr = 16'h0000;
  logic [7:0]  last_we_data = 8'h00;
  assign mem_rdata = ram[mem_addr];

  always @(posedge fpga_clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_count      <= we_count + 1;
      last_we_addr  <= mem_addr;
      last_we_data  <= mem_wdata;
    end
    if (granted) granted_count <= granted_count + 1;
  end

  // Expected memory contents.
  logic [7:0] exp_mem [logic [15:0]];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // One CPU bus cycle: phi2 high for ph clocks, then low for ph clocks.
  // Returns observations; callers do the comparisons.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input int ph, output int n_high, output int n_total,
                           output logic oe_o, output logic [7:0] rd_o, output logic cs_o);
    int c0;
    c0 = we_count;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rw    = rw;
    cpu_phi2  = 1'b1;
    repeat (ph) @(negedge fpga_clk);
    n_high   = we_count - c0;
    oe_o     = cpu_data_oe;
    rd_o     = cpu_rdata;
    cs_o     = mem_cs;
    cpu_phi2 = 1'b0;
    repeat (ph) @(negedge fpga_clk);
    n_total  = we_count - c0;
    cpu_rw   = 1'b1;
  endtask

  // Halt, drain two phi2 cycles, then wait (bounded) for the grant.
  task automatic enter_diag(output logic ok);
    int nh, nt; logic oe, cs; logic [7:0] rd;
    halt_req = 1'b1;
    @(negedge fpga_clk);
    cpu_cycle(16'h0000, 8'h00, 1'b1, 6, nh, nt, oe, rd, cs);
    cpu_cycle(16'h0000, 8'h00, 1'b1, 6, nh, nt, oe, rd, cs);
    for (int i = 0; i < 20 && !granted; i++) @(negedge fpga_clk);
    ok = granted;
  endtask

  task automatic leave_diag();
    diag_cs = 1'b0;
    diag_we = 1'b0;
    @(negedge fpga_clk);
    halt_req = 1'b0;
    repeat (3) @(negedge fpga_clk);
  endtask

  task automatic test_reset();
    fpga_reset = 1'b1;
    cpu_phi2 = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    halt_req = 1'b0; diag_address = 16'h0000; diag_data_out = 8'h00;
    diag_we = 1'b0; diag_cs = 1'b0;
    repeat (3) @(negedge fpga_clk);
    checks += 7;
    if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_cpu_rdy: got %b expected 1", cpu_rdy); end
    if (granted !== 1'b0) begin errors++; $display("FAIL reset_granted: got %b expected 0", granted); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    if (mem_cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs: got %b expected 0", mem_cs); end
    if (cpu_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", cpu_data_oe); end
    if (access_violation !== 1'b0) begin errors++; $display("FAIL reset_violation: got %b expected 0", access_violation); end
    if (diag_rdata !== 8'h00) begin errors++; $display("FAIL reset_diag_rdata: got %h expected 00", diag_rdata); end
    fpga_reset = 1'b0;
    @(negedge fpga_clk);
  endtask

  task automatic test_cpu_write();
    int nh, nt, exp_n; logic oe, cs; logic [7:0] rd; logic [15:0] a; logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin a = 16'h0200; d = 8'h5A; end
      else begin a = 16'($urandom_range(0, 65535)); d = 8'($urandom); end
      exp_n = (WP && a >= ROM_BASE_TB) ? 0 : 1;
      cpu_cycle(a, d, 1'b0, 6, nh, nt, oe, rd, cs);
      checks += 4;
      if (nh !== 0) begin errors++; $display("FAIL wr_early_strobe: got %0d expected 0", nh); end
      if (nt !== exp_n) begin errors++; $display("FAIL wr_strobe_count a=%h: got %0d expected %0d", a, nt, exp_n); end
      if (cs !== 1'b1) begin errors++; $display("FAIL wr_mem_cs: got %b expected 1", cs); end
      if (oe !== 1'b0) begin errors++; $display("FAIL wr_oe: got %b expected 0", oe); end
      if (exp_n == 1) begin
        exp_mem[a] = d;
        checks += 2;
        if (last_we_addr !== a) begin errors++; $display("FAIL wr_addr: got %h expected %h", last_we_addr, a); end
        if (last_we_data !== d) begin errors++; $display("FAIL wr_data: got %h expected %h", last_we_data, d); end
        cpu_cycle(a, 8'h00, 1'b1, 6, nh, nt, oe, rd, cs);
        checks += 3;
        if (nt !== 0) begin errors++; $display("FAIL rd_strobe: got %0d expected 0", nt); end
        if (oe !== 1'b1) begin errors++; $display("FAIL rd_oe: got %b expected 1", oe); end
        if (rd !== exp_mem[a]) begin errors++; $display("FAIL rd_data a=%h: got %h expected %h", a, rd, exp_mem[a]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nh, nt; logic oe, cs; logic [7:0] rd; logic [15:0] a; logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(0, 16'hBFFF));
      d = 8'($urandom);
      cpu_cycle(a, d, 1'b0, 4, nh, nt, oe, rd, cs);
      exp_mem[a] = d;
      checks += 3;
      if (nt !== 1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", nt); end
      if (last_we_addr !== a) begin errors++; $display("FAIL b2b_addr: got %h expected %h", last_we_addr, a); end
      if (last_we_data !== d) begin errors++; $display("FAIL b2b_data: got %h expected %h", last_we_data, d); end
    end
  endtask

  task automatic test_halt_handshake();
    int nh, nt; logic oe, cs; logic [7:0] rd; logic [15:0] a; logic [7:0] d;
    a = 16'($urandom_range(0, 16'hBFFF));
    d = 8'($urandom);
    halt_req = 1'b1;
    @(negedge fpga_clk);
    checks += 2;
    if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL halt_rdy: got %b expected 0", cpu_rdy); end
    if (granted !== 1'b0) begin errors++; $display("FAIL halt_early_grant: got %b expected 0", granted); end
    cpu_cycle(a, d, 1'b0, 6, nh, nt, oe, rd, cs);
    exp_mem[a] = d;
    checks += 3;
    if (nt !== 1) begin errors++; $display("FAIL drain_write: got %0d expected 1", nt); end
    if (last_we_data !== d) begin errors++; $display("FAIL drain_wdata: got %h expected %h", last_we_data, d); end
    if (granted !== 1'b0) begin errors++; $display("FAIL grant_after_fall1: got %b expected 0", granted); end
    cpu_cycle(a, 8'h00, 1'b1, 6, nh, nt, oe, rd, cs);
    checks += 3;
    if (rd !== exp_mem[a]) begin errors++; $display("FAIL drain_read: got %h expected %h", rd, exp_mem[a]); end
    if (granted !== 1'b1) begin errors++; $display("FAIL grant_after_fall2: got %b expected 1", granted); end
    if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL diag_rdy: got %b expected 0", cpu_rdy); end
  endtask

  task automatic test_diag_access();
    logic [15:0] a; logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin a = 16'h1234; d = 8'hA5; end
      else begin a = 16'($urandom_range(0, 65535)); d = 8'($urandom); end
      diag_address = a; diag_data_out = d; diag_cs = 1'b1; diag_we = 1'b1;
      #1;
      checks += 3;
      if (mem_we !== 1'b1) begin errors++; $display("FAIL diag_we_pass: got %b expected 1", mem_we); end
      if (mem_addr !== a) begin errors++; $display("FAIL diag_addr: got %h expected %h", mem_addr, a); end
      if (mem_wdata !== d) begin errors++; $display("FAIL diag_wdata: got %h expected %h", mem_wdata, d); end
      exp_mem[a] = d;
      @(negedge fpga_clk);
      diag_we = 1'b0;
      #1;
      checks += 3;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL diag_we_drop: got %b expected 0", mem_we); end
      if (mem_cs !== 1'b1) begin errors++; $display("FAIL diag_cs_pass: got %b expected 1", mem_cs); end
      if (diag_rdata !== exp_mem[a]) begin errors++; $display("FAIL diag_read a=%h: got %h expected %h", a, diag_rdata, exp_mem[a]); end
      @(negedge fpga_clk);
    end
    checks++;
    if (access_violation !== 1'b0) begin errors++; $display("FAIL diag_no_violation: got %b expected 0", access_violation); end
  endtask

  task automatic test_resume();
    diag_cs = 1'b0; diag_we = 1'b0;
    @(negedge fpga_clk);
    halt_req = 1'b0;
    @(negedge fpga_clk);
    checks += 3;
    if (granted !== 1'b0) begin errors++; $display("FAIL resume_grant: got %b expected 0", granted); end
    if (mem_cs !== 1'b0) begin errors++; $display("FAIL resume_cs: got %b expected 0", mem_cs); end
    if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL resume_rdy_early: got %b expected 0", cpu_rdy); end
    @(negedge fpga_clk);
    checks++;
    if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL resume_rdy: got %b expected 1", cpu_rdy); end
  endtask

  task automatic test_abort();
    int nh, nt, g0; logic oe, cs; logic [7:0] rd; logic [15:0] a; logic [7:0] d;
    g0 = granted_count;
    a = 16'($urandom_range(0, 16'hBFFF));
    d = 8'($urandom);
    halt_req = 1'b1;
    @(negedge fpga_clk);
    cpu_cycle(a, d, 1'b0, 6, nh, nt, oe, rd, cs);
    exp_mem[a] = d;
    halt_req = 1'b0;
    @(negedge fpga_clk);
    checks += 3;
    if (nt !== 1) begin errors++; $display("FAIL abort_write: got %0d expected 1", nt); end
    if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL abort_rdy: got %b expected 1", cpu_rdy); end
    if (granted_count !== g0) begin errors++; $display("FAIL abort_grant_seen: got %0d expected %0d", granted_count, g0); end
  endtask

  task automatic test_violation();
    diag_cs = 1'b1; diag_address = 16'h0040;
    #1;
    checks++;
    if (mem_cs !== 1'b0) begin errors++; $display("FAIL viol_cs_blocked: got %b expected 0", mem_cs); end
    @(negedge fpga_clk);
    diag_cs = 1'b0;
    repeat (3) @(negedge fpga_clk);
    checks++;
    if (access_violation !== 1'b1) begin errors++; $display("FAIL viol_sticky: got %b expected 1", access_violation); end
    fpga_reset = 1'b1;
    @(negedge fpga_clk);
    fpga_reset = 1'b0;
    @(negedge fpga_clk);
    checks++;
    if (access_violation !== 1'b0) begin errors++; $display("FAIL viol_cleared: got %b expected 0", access_violation); end
    diag_we = 1'b1; diag_cs = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL viol_we_blocked: got %b expected 0", mem_we); end
    @(negedge fpga_clk);
    diag_we = 1'b0;
    checks++;
    if (access_violation !== 1'b1) begin errors++; $display("FAIL viol_we_flag: got %b expected 1", access_violation); end
    fpga_reset = 1'b1;
    @(negedge fpga_clk);
    fpga_reset = 1'b0;
    @(negedge fpga_clk);
  endtask

  task automatic test_reset_in_diag();
    logic ok;
    enter_diag(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rst_diag_enter: got %b expected 1", ok); end
    diag_address = 16'h1234; diag_cs = 1'b1;
    fpga_reset = 1'b1;
    @(negedge fpga_clk);
    checks += 7;
    if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rstd_rdy: got %b expected 1", cpu_rdy); end
    if (granted !== 1'b0) begin errors++; $display("FAIL rstd_grant: got %b expected 0", granted); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rstd_we: got %b expected 0", mem_we); end
    if (mem_cs !== 1'b0) begin errors++; $display("FAIL rstd_cs: got %b expected 0", mem_cs); end
    if (cpu_data_oe !== 1'b0) begin errors++; $display("FAIL rstd_oe: got %b expected 0", cpu_data_oe); end
    if (access_violation !== 1'b0) begin errors++; $display("FAIL rstd_viol: got %b expected 0", access_violation); end
    if (diag_rdata !== 8'h00) begin errors++; $display("FAIL rstd_diag_rdata: got %h expected 00", diag_rdata); end
    fpga_reset = 1'b0; diag_cs = 1'b0; halt_req = 1'b0;
    repeat (2) @(negedge fpga_clk);
  endtask

  task automatic test_rom_protect();
    int nh, nt; logic oe, cs, ok; logic [7:0] rd; logic [7:0] d;
    d = 8'($urandom);
    cpu_cycle(16'hC000, d, 1'b0, 6, nh, nt, oe, rd, cs);
    checks++;
    if (nt !== (WP ? 0 : 1)) begin errors++; $display("FAIL rom_cpu_c000: got %0d expected %0d", nt, WP ? 0 : 1); end
    cpu_cycle(16'hBFFF, d, 1'b0, 6, nh, nt, oe, rd, cs);
    checks++;
    if (nt !== 1) begin errors++; $display("FAIL rom_cpu_bfff: got %0d expected 1", nt); end
    enter_diag(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rom_enter_diag: got %b expected 1", ok); end
    diag_address = 16'hC000; diag_data_out = d; diag_cs = 1'b1; diag_we = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rom_diag_write: got %b expected 1", mem_we); end
    @(negedge fpga_clk);
    diag_we = 1'b0;
    leave_diag();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_back_to_back();
    test_halt_handshake();
    test_diag_access();
    test_resume();
    test_abort();
    test_violation();
    test_reset_in_diag();
    test_rom_protect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/diag_bus_arbiter.md
Name: diag_bus_arbiter

Overview:
- Sits directly downstream of the diagnostics controller and in front of the memory-map RAM.
- Owns the single RAM port. The CPU bus normally drives the port. When diagnostics raises halt, the block stalls the CPU via RDY, drains in-flight bus cycles, then hands the port to the diagnostics address/data/we/cs.
- Returns RAM read data to whichever side is the owner, and flags diagnostics accesses made without ownership.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the cpu_phi2 synchroniser (minimum 2).
- SETTLE_EDGES, 2, synchronised phi2 falling edges to wait after cpu_rdy drops before granting (1..15).
- ROM_BASE, 16'hC000, lowest address treated as ROM (used only with the optional feature).

Ports:
- fpga_clk  in  1  system clock; all logic runs on its rising edge.
- fpga_reset  in  1  synchronous, active-high reset.
- cpu_phi2  in  1  CPU phase-2 clock; asynchronous to fpga_clk.
- cpu_rw  in  1  CPU read/write; 1 = read.
- cpu_addr  in  16  CPU address bus.
- cpu_wdata  in  8  CPU write data.
- cpu_rdy  out  1  CPU ready; 0 stalls the CPU.
- cpu_rdata  out  8  RAM read data to the CPU.
- cpu_data_oe  out  1  CPU data-bus drive enable.
- halt_req  in  1  halt request level from diagnostics.
- granted  out  1  diagnostics owns the RAM port.
- diag_address  in  16  diagnostics address.
- diag_data_out  in  8  diagnostics write data.
- diag_we  in  1  diagnostics write enable.
- diag_cs  in  1  diagnostics chip select.
- diag_rdata  out  8  RAM read data to diagnostics.
- mem_addr  out  16  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write strobe.
- mem_cs  out  1  RAM select.
- mem_rdata  in  8  RAM read data.
- access_violation  out  1  sticky error flag.

Behaviour:
- Reset values:
  - state = RUN.
  - cpu_rdy = 1.
  - granted = 0.
  - mem_we = 0, mem_cs = 0.
  - cpu_data_oe = 0.
  - access_violation = 0.
  - Edge counter = 0, synchroniser = 0.
- Reset mid-operation: a reset asserted while in DRAIN or DIAG abandons the operation and forces all of the above within one clock.
- phi2 handling:
  - cpu_phi2 passes through SYNC_STAGES flops to give phi2_s.
  - Rise and fall pulses are 1-clock edge detects on phi2_s.
- CPU capture: while phi2_s = 1, cpu_addr, cpu_wdata and cpu_rw are registered into the cpu_* capture registers every clock.
- State RUN:
  - Outputs:
    - mem_addr = captured address, mem_wdata = captured data.
    - mem_cs = phi2_s.
    - mem_we = 1 for exactly one clock, on the clock after a phi2_s fall, when captured rw = 0.
    - cpu_rdata = mem_rdata.
    - cpu_data_oe = phi2_s & cpu_rw.
  - Transition: when halt_req = 1, go to DRAIN, cpu_rdy <= 0 on the same edge, and clear the edge counter.
- State DRAIN:
  - CPU bus servicing continues exactly as in RUN, so that writes the CPU performs despite RDY still complete.
  - Each phi2_s fall increments the counter.
  - When the counter reaches SETTLE_EDGES, go to DIAG and set granted <= 1.
  - If halt_req drops first, return to RUN with cpu_rdy <= 1 and no grant.
- State DIAG:
  - Combinational mux: mem_addr = diag_address, mem_wdata = diag_data_out, mem_cs = diag_cs, mem_we = diag_we & diag_cs.
  - diag_rdata = mem_rdata, so the diagnostics controller sees zero added latency.
  - cpu_data_oe = 0.
  - CPU phi2 edges are ignored.
  - When halt_req = 0, go to RESUME and set granted <= 0.
- State RESUME:
  - Hold mem_cs = 0 and mem_we = 0 for one clock.
  - Then go to RUN with cpu_rdy <= 1.
- Ownership violation: diag_cs = 1 or diag_we = 1 while granted = 0 is never forwarded to RAM. It sets access_violation = 1, which stays set until reset.
- Simultaneous events: a phi2_s fall coinciding with halt_req assertion still issues the RUN write strobe. That fall does not count toward SETTLE_EDGES.
- diag_rdata outside DIAG is 8'h00.

Optional Feature:
- Macro: ROM_WRITE_PROTECT_EN.
- Defined:
  - CPU writes with captured address >= ROM_BASE are dropped (mem_we stays 0).
  - Diagnostics writes in DIAG are always permitted.
- Undefined: all CPU writes reach RAM; ROM_BASE is unused.

Test Plan:
- CPU write: RUN, cpu_addr = 16'h0200, cpu_wdata = 8'h5A, cpu_rw = 0, then phi2 high->low -> exactly one mem_we pulse with mem_addr = 16'h0200 and mem_wdata = 8'h5A. No mem_we while phi2 stays high.
- Halt handshake: halt_req = 1 with SETTLE_EDGES = 2 -> cpu_rdy = 0 on the next edge. granted = 1 only after the 2nd subsequent phi2 fall. A CPU write issued during DRAIN still produces a mem_we pulse.
- DIAG access: diag_address = 16'h1234, diag_data_out = 8'hA5, diag_cs = 1, diag_we pulsed for one clock -> mem_we pulses in the same cycle with mem_addr = 16'h1234. A read from 16'h1234 returns 8'hA5 on diag_rdata combinationally.
- Abort and resume:
  - halt_req dropped after 1 phi2 fall in DRAIN -> RUN, cpu_rdy = 1, granted never rises.
  - halt_req dropped in DIAG -> granted = 0, one clock of mem_cs = 0, then cpu_rdy = 1.
- Violation and reset: diag_cs = 1 while in RUN -> mem_cs unchanged and access_violation = 1, held until fpga_reset = 1 for one clock. A reset asserted during DIAG restores every output to its reset value at the next edge.
- ROM_WRITE_PROTECT_EN defined: CPU write to 16'hC000 -> no mem_we; CPU write to 16'hBFFF -> mem_we pulse; diagnostics write to 16'hC000 in DIAG -> mem_we pulse.
